demux_1to2_buf: RTL and testbench

//  Stream demultiplexer: routes each beat on one valid/ready input to one of two output channels per select_i.

---
 rtl/demux_1to2_buf.sv | 136 +++++++++++++
 tb/tb_demux_1to2_buf.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: valid/ready stream demultiplexer that routes each input beat to one of two
// output channels, each with its own 2-entry FIFO so a stalled consumer never blocks the other.

module demux_1to2_buf_chan #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [size-1:0] i_data,
  output logic [size-1:0] o_head,
  output logic            o_valid,
  output logic [1:0]      o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } chanState_t;

  chanState_t      r_state;
  chanState_t      w_nextState;
  logic [size-1:0] r_head;
  logic [size-1:0] r_tail;
  logic [size-1:0] w_nextHead;
  logic [size-1:0] w_nextTail;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_nextState;
      r_head  <= w_nextHead;
      r_tail  <= w_nextTail;
    end
  end

  // The state encoding doubles as the occupancy count; a push into TWO is impossible
  // because the top deasserts ready for a full channel.
  always_comb begin
    w_nextState = r_state;
    w_nextHead  = r_head;
    w_nextTail  = r_tail;
    case (r_state)
      EMPTY: begin
        if (i_push) begin
          w_nextState = ONE;
          w_nextHead  = i_data;
        end
      end
      ONE: begin
        if (i_push && i_pop) begin
          w_nextHead = i_data;
        end else if (i_push) begin
          w_nextState = TWO;
          w_nextTail  = i_data;
        end else if (i_pop) begin
          w_nextState = EMPTY;
        end
      end
      TWO: begin
        if (i_pop) begin
          w_nextState = ONE;
          w_nextHead  = r_tail;
        end
      end
      default: w_nextState = EMPTY;
    endcase
  end

  assign o_head  = r_head;
  assign o_valid = (r_state != EMPTY);
  assign o_count = r_state;

endmodule

module demux_1to2_buf #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic            select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic            valid0_o,
  input  logic            ready0_i,
  output logic [size-1:0] data1_o,
  output logic            valid1_o,
  input  logic            ready1_i,
  output logic [1:0]      count0_o,
  output logic [1:0]      count1_o
);

  logic w_push0;
  logic w_push1;
  logic w_pop0;
  logic w_pop1;
  logic w_ready;

  // Ready is derived only from registered occupancy, so no consumer ready leaks upstream.
  assign w_ready = select_i ? (count1_o != 2'd2) : (count0_o != 2'd2);
  assign ready_o = w_ready;
  assign w_push0 = valid_i && w_ready && !select_i;
  assign w_push1 = valid_i && w_ready && select_i;
  assign w_pop0  = valid0_o && ready0_i;
  assign w_pop1  = valid1_o && ready1_i;

  demux_1to2_buf_chan #(.size(size)) u_chan0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push0),
    .i_pop   (w_pop0),
    .i_data  (data_i),
    .o_head  (data0_o),
    .o_valid (valid0_o),
    .o_count (count0_o)
  );

  demux_1to2_buf_chan #(.size(size)) u_chan1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push1),
    .i_pop   (w_pop1),
    .i_data  (data_i),
    .o_head  (data1_o),
    .o_valid (valid1_o),
    .o_count (count1_o)
  );

endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb_demux_1to2_buf: directed and randomized stimulus with a queue-based scoreboard per channel.

module tb_demux_1to2_buf;

  localparam int SIZE = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [SIZE-1:0] data_i;
  logic            select_i;
  logic            valid_i;
  logic            ready_o;
  logic [SIZE-1:0] data0_o;
  logic            valid0_o;
  logic            ready0_i;
  logic [SIZE-1:0] data1_o;
  logic            valid1_o;
  logic            ready1_i;
  logic [1:0]      count0_o;
  logic [1:0]      count1_o;

  int nChecks = 0;
  int nFails  = 0;

  // Model: each queue holds exactly what the channel FIFO should contain, head first.
  logic [SIZE-1:0] q0[$];
  logic [SIZE-1:0] q1[$];
  logic            readyExp = 1'b1;
  logic            pendValid = 1'b0;
  logic            pendSel = 1'b0;
  logic [SIZE-1:0] pendData = '0;

  demux_1to2_buf #(.size(SIZE)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .select_i (select_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .ready0_i (ready0_i),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i),
    .count0_o (count0_o),
    .count1_o (count1_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beats accepted at the previous edge enter the model before the next inputs are chosen.
  task automatic commitPush();
    if (pendValid) begin
      if (pendSel) q1.push_back(pendData);
      else         q0.push_back(pendData);
    end
    pendValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [SIZE-1:0] d,
                               input logic r0, input logic r1);
    @(posedge clk_i);
    #1;
    commitPush();
    valid_i  = v;
    select_i = s;
    data_i   = d;
    ready0_i = r0;
    ready1_i = r1;
    readyExp = s ? (q1.size() != 2) : (q0.size() != 2);
    pendValid = v && readyExp;
    pendSel   = s;
    pendData  = d;
  endtask

  task automatic sendBeat(input logic s, input logic [SIZE-1:0] d, input logic r0, input logic r1);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      applyStimulus(1'b1, s, d, r0, r1);
      done = pendValid;
    end
    if (!done) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL accept_timeout: got not-accepted expected accepted for 0x%0h", d);
    end
  endtask

  task automatic idle(input int n, input logic r0, input logic r1);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, SIZE'($urandom), r0, r1);
  endtask

  task automatic pulseReset();
    @(posedge clk_i);
    #2;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    #1;
    checkOutput("rst_valid0", SIZE'(valid0_o), 0);
    checkOutput("rst_valid1", SIZE'(valid1_o), 0);
    checkOutput("rst_count0", SIZE'(count0_o), 0);
    checkOutput("rst_count1", SIZE'(count1_o), 0);
    checkOutput("rst_data0", data0_o, 0);
    checkOutput("rst_data1", data1_o, 0);
    q0.delete();
    q1.delete();
    pendValid = 1'b0;
    readyExp  = 1'b1;
    #1;
    rst_i = 1'b1;
  endtask

  // Monitor: compares DUT outputs with the model between edges and retires popped beats.
  always @(negedge clk_i) begin
    if (rst_i) begin
      checkOutput("ready_o", SIZE'(ready_o), SIZE'(readyExp));
      checkOutput("count0", SIZE'(count0_o), SIZE'(q0.size()));
      checkOutput("count1", SIZE'(count1_o), SIZE'(q1.size()));
      checkOutput("valid0", SIZE'(valid0_o), SIZE'(q0.size() != 0));
      checkOutput("valid1", SIZE'(valid1_o), SIZE'(q1.size() != 0));
      if (q0.size() != 0) begin
        checkOutput("data0", data0_o, q0[0]);
        if (ready0_i) void'(q0.pop_front());
      end
      if (q1.size() != 0) begin
        checkOutput("data1", data1_o, q1[0]);
        if (ready1_i) void'(q1.pop_front());
      end
    end
  end

  initial begin
    logic            v, s, r0, r1;
    logic [SIZE-1:0] d;

    rst_i    = 1'b0;
    valid_i  = 1'b1;
    select_i = 1'b0;
    data_i   = 32'hDEADBEEF;
    ready0_i = 1'b1;
    ready1_i = 1'b1;
    #12;
    checkOutput("init_ready", SIZE'(ready_o), 1);
    checkOutput("init_valid0", SIZE'(valid0_o), 0);
    checkOutput("init_valid1", SIZE'(valid1_o), 0);
    checkOutput("init_count0", SIZE'(count0_o), 0);
    checkOutput("init_count1", SIZE'(count1_o), 0);
    checkOutput("init_data0", data0_o, 0);
    checkOutput("init_data1", data1_o, 0);
    valid_i = 1'b0;
    #1;
    rst_i = 1'b1;

    // Routing
    sendBeat(1'b0, 32'hA5A5A5A5, 1'b1, 1'b1);
    sendBeat(1'b1, 32'h12345678, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);

    // Full channel 0 with backpressure, channel 1 still accepting
    sendBeat(1'b0, 32'h1, 1'b0, 1'b1);
    sendBeat(1'b0, 32'h2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h3, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h3, 1'b0, 1'b1);
    sendBeat(1'b1, 32'h77, 1'b0, 1'b1);
    sendBeat(1'b0, 32'h3, 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);

    // Simultaneous push and pop while holding one beat
    sendBeat(1'b0, 32'h10, 1'b0, 1'b1);
    sendBeat(1'b0, 32'h20, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);

    // Cross-channel concurrency
    sendBeat(1'b0, 32'hC0, 1'b0, 1'b0);
    sendBeat(1'b0, 32'hC1, 1'b0, 1'b0);
    sendBeat(1'b1, 32'hD0, 1'b0, 1'b0);
    sendBeat(1'b1, 32'hD1, 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);

    // Mid-operation asynchronous reset with both channels full
    sendBeat(1'b0, 32'hE0, 1'b0, 1'b0);
    sendBeat(1'b0, 32'hE1, 1'b0, 1'b0);
    sendBeat(1'b1, 32'hF0, 1'b0, 1'b0);
    sendBeat(1'b1, 32'hF1, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    pulseReset();
    idle(2, 1'b1, 1'b1);
    sendBeat(1'b0, 32'hBEEF0001, 1'b1, 1'b1);
    sendBeat(1'b1, 32'hBEEF0002, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);

    // Randomized traffic; a stalled beat is held stable until accepted
    v = 1'b0;
    s = 1'b0;
    d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(v && !pendValid)) begin
        v = ($urandom_range(0, 3) != 0);
        s = 1'($urandom);
        d = SIZE'($urandom);
      end
      r0 = ($urandom_range(0, 2) != 0);
      r1 = ($urandom_range(0, 3) == 0);
      applyStimulus(v, s, d, r0, r1);
    end
    idle(8, 1'b1, 1'b1);
    @(posedge clk_i);
    #1;
    commitPush();
    checkOutput("drain_q0", SIZE'(q0.size()), 0);
    checkOutput("drain_q1", SIZE'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
